// File: rtl/kpac_pkg.sv
// Shared key codes, state encoding and helpers for the keypad access controller.
// Optional lockout auto-expiry is enabled with KPAC_LOCK_TIMER_EN.
package kpac_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;
    localparam logic [3:0] KEY_NONE = 4'hF;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_GET_ID   = 4'd1;
    localparam logic [3:0] ST_ID_STAR  = 4'd2;
    localparam logic [3:0] ST_GET_PIN  = 4'd3;
    localparam logic [3:0] ST_PIN_HASH = 4'd4;
    localparam logic [3:0] ST_CHECK    = 4'd5;
    localparam logic [3:0] ST_ADMIN    = 4'd6;
    localparam logic [3:0] ST_ADM_ID   = 4'd7;
    localparam logic [3:0] ST_ADM_STAR = 4'd8;
    localparam logic [3:0] ST_ADM_PIN  = 4'd9;
    localparam logic [3:0] ST_ADM_HASH = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_GET_ID   = ST_GET_ID,
        S_ID_STAR  = ST_ID_STAR,
        S_GET_PIN  = ST_GET_PIN,
        S_PIN_HASH = ST_PIN_HASH,
        S_CHECK    = ST_CHECK,
        S_ADMIN    = ST_ADMIN,
        S_ADM_ID   = ST_ADM_ID,
        S_ADM_STAR = ST_ADM_STAR,
        S_ADM_PIN  = ST_ADM_PIN,
        S_ADM_HASH = ST_ADM_HASH
    } kpac_state_e;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_admin_state(input kpac_state_e s);
        return s inside {S_ADMIN, S_ADM_ID, S_ADM_STAR,
                         S_ADM_PIN, S_ADM_HASH};
    endfunction

endpackage

// File: rtl/kpac_key_event.sv
// Keypad input register and press-edge detector: one strobe per key press.
// Part of keypad_access_ctrl (KPAC_LOCK_TIMER_EN does not affect this block).
module kpac_key_event
    import kpac_pkg::*;
(
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] keypad,
    output logic       evt,
    output logic [3:0] code
);

    logic [3:0] key_q, key_d;
    logic [3:0] prev_q, prev_d;

    always_comb begin
        key_d  = keypad;
        prev_d = key_q;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            key_q  <= KEY_NONE;
            prev_q <= KEY_NONE;
        end else begin
            key_q  <= key_d;
            prev_q <= prev_d;
        end
    end

    // Only the released-to-pressed transition counts, so a held key never repeats.
    assign evt  = (key_q != KEY_NONE) && (prev_q == KEY_NONE);
    assign code = key_q;

endmodule

// File: rtl/keypad_access_ctrl.sv
// Keypad login/admin controller: user ID + PIN entry, per-user lockout, admin PIN writes.
// Define KPAC_LOCK_TIMER_EN to let locks expire after LOCKOUT_CYC cycles.
module keypad_access_ctrl
    import kpac_pkg::*;
#(
    parameter int NUM_USERS   = 8,
    parameter int PIN_DIGITS  = 4,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 50000,
    parameter int LOCKOUT_CYC = 500000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] keypad,
    output logic       grant,
    output logic       deny,
    output logic       locked_out,
    output logic [3:0] user_id,
    output logic       admin_mode,
    output logic       pin_wr_ack,
    output logic       busy
);

    localparam int PW = PIN_DIGITS * 4;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] NU   = 4'(NUM_USERS);
    localparam logic [3:0] MAXT = 4'(MAX_TRIES);
    localparam logic [3:0] LAST = 4'(PIN_DIGITS - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

    logic       evt;
    logic [3:0] code;

    kpac_key_event u_key (
        .clk    (clk),
        .RST    (RST),
        .keypad (keypad),
        .evt    (evt),
        .code   (code)
    );

    kpac_state_e state_q, state_d;
    logic [3:0]    id_q, id_d;
    logic [3:0]    adm_id_q, adm_id_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [PW-1:0] entry_q, entry_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [PW-1:0] pin_q [NUM_USERS];
    logic [PW-1:0] pin_d [NUM_USERS];
    logic [3:0]    fail_q [NUM_USERS];
    logic [3:0]    fail_d [NUM_USERS];
    logic          grant_q, grant_d;
    logic          deny_q, deny_d;
    logic          lo_q, lo_d;
    logic [3:0]    uid_q, uid_d;
    logic          adm_q, adm_d;
    logic          ack_q, ack_d;

    logic [PW-1:0] sel_pin;
    logic [3:0]    sel_fail;
    logic          timeout;
    logic          digit;

`ifdef KPAC_LOCK_TIMER_EN
    localparam int LW = $clog2(LOCKOUT_CYC + 1);
    logic [LW-1:0] lk_tmr_q, lk_tmr_d;
    logic          lk_run_q, lk_run_d;
    logic          new_lock;
`endif

    always_comb begin
        sel_pin  = '0;
        sel_fail = '0;
        for (int u = 0; u < NUM_USERS; u++) begin
            if (id_q == 4'(u)) begin
                sel_pin  = pin_q[u];
                sel_fail = fail_q[u];
            end
        end
    end

    assign digit   = is_digit(code);
    assign timeout = (state_q != S_IDLE) && !evt && (tmr_q == TLAST);

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        adm_id_d = adm_id_q;
        cnt_d    = cnt_q;
        entry_d  = entry_q;
        pin_d    = pin_q;
        fail_d   = fail_q;
        grant_d  = 1'b0;
        deny_d   = 1'b0;
        lo_d     = 1'b0;
        ack_d    = 1'b0;
        uid_d    = uid_q;
        tmr_d    = tmr_q + TW'(1);
        if (evt || state_q == S_IDLE) tmr_d = '0;

        if (timeout) begin
            state_d = S_IDLE;
            // An idle admin session just logs out; any half-typed entry is rejected.
            if (state_q != S_ADMIN) begin
                deny_d = 1'b1;
                uid_d  = is_admin_state(state_q) ? adm_id_q : id_q;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (evt && code == KEY_STAR) begin
                        state_d = S_GET_ID;
                        id_d    = '0;
                    end
                end
                S_GET_ID: begin
                    if (evt) begin
                        if (digit) begin
                            id_d    = code;
                            state_d = S_ID_STAR;
                        end else begin
                            state_d = S_IDLE;
                            deny_d  = 1'b1;
                            uid_d   = id_q;
                        end
                    end
                end
                S_ID_STAR: begin
                    if (evt) begin
                        if (code == KEY_STAR) begin
                            state_d = S_GET_PIN;
                            cnt_d   = '0;
                            entry_d = '0;
                        end else begin
                            state_d = S_IDLE;
                            deny_d  = 1'b1;
                            uid_d   = id_q;
                        end
                    end
                end
                S_GET_PIN: begin
                    if (evt) begin
                        if (digit) begin
                            entry_d = (entry_q << 4) | PW'(code);
                            cnt_d   = cnt_q + 4'd1;
                            if (cnt_q == LAST) state_d = S_PIN_HASH;
                        end else begin
                            state_d = S_IDLE;
                            deny_d  = 1'b1;
                            uid_d   = id_q;
                        end
                    end
                end
                S_PIN_HASH: begin
                    if (evt) begin
                        if (code == KEY_HASH) begin
                            state_d = S_CHECK;
                        end else begin
                            state_d = S_IDLE;
                            deny_d  = 1'b1;
                            uid_d   = id_q;
                        end
                    end
                end
                S_CHECK: begin
                    state_d = S_IDLE;
                    uid_d   = id_q;
                    if (id_q >= NU) begin
                        deny_d = 1'b1;
                    end else if (sel_fail == MAXT) begin
                        deny_d = 1'b1;
                        lo_d   = 1'b1;
                    end else if (entry_q == sel_pin) begin
                        grant_d = 1'b1;
                        if (id_q == 4'd0) state_d = S_ADMIN;
                        for (int u = 0; u < NUM_USERS; u++)
                            if (id_q == 4'(u)) fail_d[u] = '0;
                    end else begin
                        deny_d = 1'b1;
                        for (int u = 0; u < NUM_USERS; u++)
                            if (id_q == 4'(u)) fail_d[u] = fail_q[u] + 4'd1;
                    end
                end
                S_ADMIN: begin
                    if (evt && code == KEY_HASH) begin
                        state_d  = S_ADM_ID;
                        adm_id_d = '0;
                    end else if (evt && code == KEY_STAR) begin
                        state_d = S_IDLE;
                    end
                end
                S_ADM_ID: begin
                    if (evt) begin
                        if (digit) begin
                            adm_id_d = code;
                            state_d  = S_ADM_STAR;
                        end else begin
                            state_d = S_ADMIN;
                            deny_d  = 1'b1;
                            uid_d   = adm_id_q;
                        end
                    end
                end
                S_ADM_STAR: begin
                    if (evt) begin
                        if (code == KEY_STAR) begin
                            state_d = S_ADM_PIN;
                            cnt_d   = '0;
                            entry_d = '0;
                        end else begin
                            state_d = S_ADMIN;
                            deny_d  = 1'b1;
                            uid_d   = adm_id_q;
                        end
                    end
                end
                S_ADM_PIN: begin
                    if (evt) begin
                        if (digit) begin
                            entry_d = (entry_q << 4) | PW'(code);
                            cnt_d   = cnt_q + 4'd1;
                            if (cnt_q == LAST) state_d = S_ADM_HASH;
                        end else begin
                            state_d = S_ADMIN;
                            deny_d  = 1'b1;
                            uid_d   = adm_id_q;
                        end
                    end
                end
                S_ADM_HASH: begin
                    if (evt) begin
                        state_d = S_ADMIN;
                        uid_d   = adm_id_q;
                        if (code == KEY_HASH && adm_id_q < NU) begin
                            ack_d = 1'b1;
                            for (int u = 0; u < NUM_USERS; u++) begin
                                if (adm_id_q == 4'(u)) begin
                                    pin_d[u]  = entry_q;
                                    fail_d[u] = '0;
                                end
                            end
                        end else begin
                            deny_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

`ifdef KPAC_LOCK_TIMER_EN
        // A fresh lock anywhere restarts the shared window; expiry frees every locked user.
        new_lock = 1'b0;
        for (int u = 0; u < NUM_USERS; u++)
            if (fail_d[u] == MAXT && fail_q[u] != MAXT) new_lock = 1'b1;
        lk_run_d = lk_run_q;
        lk_tmr_d = lk_tmr_q;
        if (new_lock) begin
            lk_run_d = 1'b1;
            lk_tmr_d = '0;
        end else if (lk_run_q) begin
            if (lk_tmr_q == LW'(LOCKOUT_CYC - 1)) begin
                lk_run_d = 1'b0;
                lk_tmr_d = '0;
                for (int u = 0; u < NUM_USERS; u++)
                    if (fail_q[u] == MAXT) fail_d[u] = '0;
            end else begin
                lk_tmr_d = lk_tmr_q + LW'(1);
            end
        end
`endif

        adm_d = is_admin_state(state_d);
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            adm_id_q <= '0;
            cnt_q    <= '0;
            entry_q  <= '0;
            tmr_q    <= '0;
            grant_q  <= 1'b0;
            deny_q   <= 1'b0;
            lo_q     <= 1'b0;
            uid_q    <= '0;
            adm_q    <= 1'b0;
            ack_q    <= 1'b0;
            for (int u = 0; u < NUM_USERS; u++) begin
                pin_q[u]  <= '0;
                fail_q[u] <= '0;
            end
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            adm_id_q <= adm_id_d;
            cnt_q    <= cnt_d;
            entry_q  <= entry_d;
            tmr_q    <= tmr_d;
            grant_q  <= grant_d;
            deny_q   <= deny_d;
            lo_q     <= lo_d;
            uid_q    <= uid_d;
            adm_q    <= adm_d;
            ack_q    <= ack_d;
            for (int u = 0; u < NUM_USERS; u++) begin
                pin_q[u]  <= pin_d[u];
                fail_q[u] <= fail_d[u];
            end
        end
    end

`ifdef KPAC_LOCK_TIMER_EN
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            lk_tmr_q <= '0;
            lk_run_q <= 1'b0;
        end else begin
            lk_tmr_q <= lk_tmr_d;
            lk_run_q <= lk_run_d;
        end
    end
`endif

    assign grant      = grant_q;
    assign deny       = deny_q;
    assign locked_out = lo_q;
    assign user_id    = uid_q;
    assign admin_mode = adm_q;
    assign pin_wr_ack = ack_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_ADMIN);

endmodule
